hamming_byte_assembler: RTL

HAMMING_BYTE_ASSEMBLER -- requirements
Module: hamming_byte_assembler

---
 rtl/hamming_byte_assembler_pkg.sv | 26 ++
 rtl/hamming_byte_assembler_fifo.sv | 66 ++++++
 rtl/hamming_byte_assembler.sv | 109 ++++++++++
 3 files changed

// File: rtl/hamming_byte_assembler_pkg.sv
// Shared types and constants for the Hamming(7,4) byte assembler.
// Codeword positions are zero-based indices into code_in.
package hamming_byte_assembler_pkg;

    typedef enum logic {
        LOW_WAIT  = 1'b0,
        HIGH_WAIT = 1'b1
    } pair_state_e;

    localparam int DEF_FIFO_DEPTH = 4;

    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D3 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D5 = 4;
    localparam int POS_D6 = 5;
    localparam int POS_D7 = 6;

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        syndrome = {cw[POS_P4] ^ cw[POS_D5] ^ cw[POS_D6] ^ cw[POS_D7],
                    cw[POS_P2] ^ cw[POS_D3] ^ cw[POS_D6] ^ cw[POS_D7],
                    cw[POS_P1] ^ cw[POS_D3] ^ cw[POS_D5] ^ cw[POS_D7]};
    endfunction

endpackage

// File: rtl/hamming_byte_assembler_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow flag.
// A push into a full FIFO only succeeds if the head pops on the same edge.
module rx_byte_fifo
    import hamming_byte_assembler_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       rd_ready,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic [3:0] count,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    cnt;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign full    = (cnt == 4'(DEPTH));
    assign do_pop  = ena && !clr && rd_ready && (cnt != 4'd0);
    assign do_push = ena && !clr && push && (!full || do_pop);
    assign drop    = ena && !clr && push && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= 4'd0;
            overflow <= 1'b0;
        end else if (ena && clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) cnt <= cnt + 4'd1;
            else if (do_pop && !do_push) cnt <= cnt - 4'd1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked until an entry exists.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata  = (cnt != 4'd0) ? mem[rd_ptr] : 8'h00;
    assign rvalid = ena && (cnt != 4'd0);
    assign count  = cnt;

endmodule

// File: rtl/hamming_byte_assembler.sv
// Decodes Hamming(7,4) codewords, pairs nibbles low-then-high into bytes
// and queues them in a small FIFO for the consumer.
module hamming_byte_assembler
    import hamming_byte_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sync_clr,
    input  logic [6:0] code_in,
    input  logic       code_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       corrected,
    output logic [7:0] corr_count,
    output logic       half_pending,
    output logic       overflow,
    output logic [3:0] fifo_count
);

    logic [2:0]  syn;
    logic [6:0]  fixed;
    logic [3:0]  nib;
    logic [3:0]  dec_nib;
    logic        dec_valid;
    logic        corr_q;
    logic [3:0]  low_q;
    logic        take;
    logic        push;
    pair_state_e state_q;
    pair_state_e state_d;

    always_comb begin
        syn   = syndrome(code_in);
        fixed = code_in;
        for (int i = 0; i < 7; i++) begin
            if (syn == 3'(i + 1)) fixed[i] = ~code_in[i];
        end
        nib = {fixed[POS_D7], fixed[POS_D6], fixed[POS_D5], fixed[POS_D3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_nib    <= 4'd0;
            dec_valid  <= 1'b0;
            corr_q     <= 1'b0;
            corr_count <= 8'd0;
        end else if (ena) begin
            dec_nib   <= nib;
            dec_valid <= code_valid && !sync_clr;
            corr_q    <= code_valid && !sync_clr && (syn != 3'd0);
            if (code_valid && !sync_clr && (syn != 3'd0) && (corr_count != 8'hFF))
                corr_count <= corr_count + 8'd1;
        end
    end

    assign corrected = corr_q && ena;
    assign take      = ena && !sync_clr && dec_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW_WAIT;
            low_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (take && state_q == LOW_WAIT) low_q <= dec_nib;
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            LOW_WAIT: begin
                if (take) state_d = HIGH_WAIT;
            end
            HIGH_WAIT: begin
                if (take) begin
                    push    = 1'b1;
                    state_d = LOW_WAIT;
                end
            end
            default: state_d = LOW_WAIT;
        endcase
        if (ena && sync_clr) state_d = LOW_WAIT;
    end

    assign half_pending = (state_q == HIGH_WAIT);

    rx_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clr      (sync_clr),
        .push     (push),
        .wdata    ({dec_nib, low_q}),
        .rd_ready (byte_ready),
        .rdata    (byte_out),
        .rvalid   (byte_valid),
        .count    (fifo_count),
        .overflow (overflow)
    );

endmodule
